// File: rtl/deoxys_pkg.sv
// rtl/deoxys_pkg.sv - shared constants, state encoding and xtime helper for the Deoxys round controller
package deoxys_pkg;

    localparam int          NUM_RNDS = 16;
    localparam logic [7:0]  RC_INIT  = 8'h2f;
    localparam logic [7:0]  RC_POLY  = 8'h1b;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? RC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/deoxys_rc_lfsr.sv
// rtl/deoxys_rc_lfsr.sv - running round-constant LFSR, RNDS_PER_CLK xtime steps per advance
module deoxys_rc_lfsr
    import deoxys_pkg::*;
#(
    parameter int RNDS_PER_CLK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       reload,
    output logic [7:0] rc_base
);

    logic [7:0] rc_q;
    logic [7:0] rc_d;
    logic [7:0] rc_step;

    always_comb begin
        rc_step = rc_q;
        for (int i = 0; i < RNDS_PER_CLK; i++) begin
            rc_step = xtime(rc_step);
        end
        rc_d = rc_q;
        // reload wins so the last round leaves the constant ready for the next block
        if (reload) begin
            rc_d = RC_INIT;
        end else if (step) begin
            rc_d = rc_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rc_q <= RC_INIT;
        end else begin
            rc_q <= rc_d;
        end
    end

    assign rc_base = rc_q;

endmodule

// File: rtl/deoxys_round_ctrl.sv
// rtl/deoxys_round_ctrl.sv - round-group sequencer with valid/ready block handshakes
module deoxys_round_ctrl
    import deoxys_pkg::*;
#(
    parameter int RNDS_PER_CLK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       load,
    output logic       round_en,
    output logic [5:0] cnt,
    output logic       first_rnd,
    output logic       last_rnd,
    output logic [7:0] rc_base,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int         NCLK     = NUM_RNDS / RNDS_PER_CLK;
    localparam logic [5:0] CNT_LAST = 6'(NCLK - 1);

    if (!(RNDS_PER_CLK == 1 || RNDS_PER_CLK == 2 || RNDS_PER_CLK == 4 ||
          RNDS_PER_CLK == 8 || RNDS_PER_CLK == 16)) begin : g_bad_rnds
        $error("RNDS_PER_CLK must be 1, 2, 4, 8 or 16");
    end

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       cnt_at_last;

    assign cnt_at_last = (cnt_q == CNT_LAST);

    always_comb begin
        in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
        load     = in_valid & in_ready;
        state_d  = state_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = ROUND;
                    cnt_d   = 6'd0;
                end
            end
            ROUND: begin
                if (cnt_at_last) begin
                    state_d = DONE;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DONE: begin
                // a block waiting upstream starts immediately, no idle bubble
                if (out_ready) begin
                    state_d = in_valid ? ROUND : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign round_en  = (state_q == ROUND);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign cnt       = cnt_q;
    assign first_rnd = round_en & (cnt_q == 6'd0);
    assign last_rnd  = round_en & cnt_at_last;

    deoxys_rc_lfsr #(
        .RNDS_PER_CLK(RNDS_PER_CLK)
    ) u_rc_lfsr (
        .clk    (clk),
        .rst    (rst),
        .step   (round_en & ~cnt_at_last),
        .reload (round_en & cnt_at_last),
        .rc_base(rc_base)
    );

endmodule

// File: tb/tb_deoxys_round_ctrl.sv
// tb/tb_deoxys_round_ctrl.sv - directed vector bench for deoxys_round_ctrl
module tb_deoxys_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, load, round_en, first_rnd, last_rnd, busy, out_valid;
    logic [5:0] cnt;
    logic [7:0] rc_base;

    logic             sw_iv = 1'b0;
    logic             sw_ordy = 1'b1;
    logic [3:0]       sw_ir, sw_ld, sw_re, sw_fr, sw_lr, sw_busy, sw_ov;
    logic [3:0][5:0]  sw_cnt;
    logic [3:0][7:0]  sw_rc;

    int errors = 0;
    int checks = 0;

    logic [7:0] lut [17] = '{8'h2f, 8'h5e, 8'hbc, 8'h63, 8'hc6, 8'h97, 8'h35, 8'h6a, 8'hd4,
                             8'hb3, 8'h7d, 8'hfa, 8'hef, 8'hc5, 8'h91, 8'h39, 8'h72};

    always #5 clk = ~clk;

    deoxys_round_ctrl #(.RNDS_PER_CLK(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .load(load),
        .round_en(round_en), .cnt(cnt), .first_rnd(first_rnd), .last_rnd(last_rnd),
        .rc_base(rc_base), .busy(busy), .out_valid(out_valid), .out_ready(out_ready)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sw
        deoxys_round_ctrl #(.RNDS_PER_CLK(2 << g)) u_sw (
            .clk(clk), .rst(rst), .in_valid(sw_iv), .in_ready(sw_ir[g]), .load(sw_ld[g]),
            .round_en(sw_re[g]), .cnt(sw_cnt[g]), .first_rnd(sw_fr[g]), .last_rnd(sw_lr[g]),
            .rc_base(sw_rc[g]), .busy(sw_busy[g]), .out_valid(sw_ov[g]), .out_ready(sw_ordy)
        );
    end

    typedef struct {
        logic       iv, ordy;
        logic       e_ir, e_ld, e_re, e_fr, e_lr, e_ov, e_busy;
        logic [5:0] e_cnt;
        logic [7:0] e_rc;
    } vec_t;

    vec_t vt [20];

    function automatic vec_t mk(input logic iv, input logic ordy, input logic ir, input logic ld,
                                input logic re, input logic fr, input logic lr, input logic ov,
                                input logic bsy, input logic [5:0] c, input logic [7:0] rc);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.e_ir = ir; v.e_ld = ld; v.e_re = re; v.e_fr = fr;
        v.e_lr = lr; v.e_ov = ov; v.e_busy = bsy; v.e_cnt = c; v.e_rc = rc;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ov(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk(nm, int'(out_valid), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int loads[$];
        int viol, bubble, done_loads, n;
        bit prev_load;
        int rounds [4];
        int rcbad [4];
        int both [4];
        logic [7:0] rc4_c1, rc8_c1;

        vt[0] = mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 6'd0, 8'h2f);
        for (int i = 1; i <= 16; i++) begin
            vt[i] = mk(0, 0, 0, 0, 1, i == 1, i == 16, 0, 1, 6'(i - 1), lut[i-1]);
        end
        vt[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 6'd0, 8'h2f);
        vt[18] = mk(0, 1, 1, 0, 0, 0, 0, 1, 1, 6'd0, 8'h2f);
        vt[19] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 6'd0, 8'h2f);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_rc_base", int'(rc_base), 8'h2f);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_round_en", int'(round_en), 0);
        chk("rst_load", int'(load), 0);

        // single block, cycle by cycle
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            in_valid  = vt[k].iv;
            out_ready = vt[k].ordy;
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", k), int'(in_ready), int'(vt[k].e_ir));
            chk($sformatf("v%0d_load", k), int'(load), int'(vt[k].e_ld));
            chk($sformatf("v%0d_round_en", k), int'(round_en), int'(vt[k].e_re));
            chk($sformatf("v%0d_first", k), int'(first_rnd), int'(vt[k].e_fr));
            chk($sformatf("v%0d_last", k), int'(last_rnd), int'(vt[k].e_lr));
            chk($sformatf("v%0d_out_valid", k), int'(out_valid), int'(vt[k].e_ov));
            chk($sformatf("v%0d_busy", k), int'(busy), int'(vt[k].e_busy));
            chk($sformatf("v%0d_cnt", k), int'(cnt), int'(vt[k].e_cnt));
            chk($sformatf("v%0d_rc_base", k), int'(rc_base), int'(vt[k].e_rc));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;

        // output backpressure
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_ov("bp_wait_out_valid");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_out_valid", i), int'(out_valid), 1);
            chk($sformatf("bp%0d_in_ready", i), int'(in_ready), 0);
            chk($sformatf("bp%0d_cnt", i), int'(cnt), 0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_busy", int'(busy), 0);
        chk("bp_idle_out_valid", int'(out_valid), 0);

        // back-to-back with in_valid held through ROUND
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b1;
        viol = 0; bubble = 0; done_loads = 0; prev_load = 1'b0;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            if (prev_load && !round_en) bubble++;
            if (round_en && (in_ready || load)) viol++;
            if (load) begin
                loads.push_back(c);
                if (out_valid) done_loads++;
            end
            prev_load = load;
            @(posedge clk); #1;
            if (c == 34) in_valid = 1'b0;
        end
        chk("b2b_load_count", loads.size(), 3);
        if (loads.size() >= 3) begin
            chk("b2b_period0", loads[1] - loads[0], 17);
            chk("b2b_period1", loads[2] - loads[1], 17);
        end
        chk("b2b_loads_in_done", done_loads, 2);
        chk("b2b_round_ready_viol", viol, 0);
        chk("b2b_bubble", bubble, 0);
        wait_ov("b2b_wait_out_valid");
        @(posedge clk); #1;
        out_ready = 1'b0;

        // mid-operation reset at cnt==7
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (cnt != 6'd7 && n < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk("mr_reached_cnt7", int'(cnt), 7);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("mr_busy", int'(busy), 0);
        chk("mr_cnt", int'(cnt), 0);
        chk("mr_rc_base", int'(rc_base), 8'h2f);
        chk("mr_out_valid", int'(out_valid), 0);
        chk("mr_round_en", int'(round_en), 0);
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_ov("mr_next_block_out_valid");
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // parameter sweep over RNDS_PER_CLK = 2, 4, 8, 16
        for (int g = 0; g < 4; g++) begin
            rounds[g] = 0; rcbad[g] = 0; both[g] = 0;
        end
        rc4_c1 = 8'h00; rc8_c1 = 8'h00;
        sw_iv = 1'b1;
        @(posedge clk); #1;
        sw_iv = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                if (sw_re[g]) begin
                    rounds[g]++;
                    if (((2 << g) * int'(sw_cnt[g])) > 16) rcbad[g]++;
                    else if (sw_rc[g] !== lut[(2 << g) * int'(sw_cnt[g])]) rcbad[g]++;
                    if (sw_fr[g] && sw_lr[g]) both[g]++;
                    if (g == 1 && sw_cnt[g] == 6'd1) rc4_c1 = sw_rc[g];
                    if (g == 2 && sw_cnt[g] == 6'd1) rc8_c1 = sw_rc[g];
                end
            end
            @(posedge clk); #1;
        end
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("sw_p%0d_rounds", 2 << g), rounds[g], 16 / (2 << g));
            chk($sformatf("sw_p%0d_rc_mismatches", 2 << g), rcbad[g], 0);
        end
        chk("sw_p4_cnt1_rc", int'(rc4_c1), 8'hc6);
        chk("sw_p8_cnt1_rc", int'(rc8_c1), 8'hd4);
        chk("sw_p16_first_and_last", both[3], 1);
        chk("sw_all_idle", int'(sw_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
